// File: rtl/subtractor_iterative_32b.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_iterative_32b
// Description : Multi-cycle subtract/compare unit. Computes
//               diff = in0 - in1 - bin one DIGIT_W-bit digit per cycle,
//               least-significant digit first, through a single a + ~b + c
//               adder slice. Also produces borrow-out and compare flags
//               (eq, ltu, lt). Request and result use val/rdy handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_iterative_32b #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             bin,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             eq,
    output logic             ltu,
    output logic             lt
);

    // Number of CALC cycles; derived from the operand and digit widths.
    localparam int NDIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] c_last_digit = CNT_W'(NDIGITS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operand registers shift right one digit per CALC cycle, so the digit
    // being processed is always at the bottom. On the final digit the bottom
    // digit holds the original top digit, whose MSB is the operand sign.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bout;
    logic             r_eq;
    logic             r_ltu;
    logic             r_lt;

    logic [DIGIT_W:0]         w_sum;
    logic [DIGIT_W-1:0]       w_digit;
    logic                     w_carry_out;
    logic [WIDTH+DIGIT_W-1:0] w_diff_cat;
    logic [WIDTH-1:0]         w_diff_full;
    logic                     w_last;
    logic                     w_accept;
    logic                     w_calc;
    logic                     w_sign_a;
    logic                     w_sign_b;
    logic                     w_ovf;

    // One digit of a + ~b + carry; carry is the inverted running borrow.
    assign w_sum       = {1'b0, r_a[DIGIT_W-1:0]}
                       + {1'b0, ~r_b[DIGIT_W-1:0]}
                       + {{DIGIT_W{1'b0}}, r_carry};
    assign w_digit     = w_sum[DIGIT_W-1:0];
    assign w_carry_out = w_sum[DIGIT_W];

    // New digit enters at the top of the result register; after NDIGITS
    // shifts the least-significant digit has reached the bottom.
    assign w_diff_cat  = {w_digit, r_diff};
    assign w_diff_full = w_diff_cat[WIDTH+DIGIT_W-1:DIGIT_W];

    assign w_last   = (r_cnt == c_last_digit);
    assign w_accept = (r_state == ST_IDLE) && istream_val;
    assign w_calc   = (r_state == ST_CALC);

    // Signed overflow of the subtraction: operand signs differ and the
    // result sign differs from the minuend sign.
    assign w_sign_a = r_a[DIGIT_W-1];
    assign w_sign_b = r_b[DIGIT_W-1];
    assign w_ovf    = (w_sign_a != w_sign_b) && (w_diff_full[WIDTH-1] != w_sign_a);

    assign diff = r_diff;
    assign bout = r_bout;
    assign eq   = r_eq;
    assign ltu  = r_ltu;
    assign lt   = r_lt;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs, decoded purely from the state.
    always_comb begin
        w_state_next = r_state;
        istream_rdy  = 1'b0;
        ostream_val  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then process one digit per cycle
    // and register the flags alongside the final digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_bout  <= 1'b0;
            r_eq    <= 1'b0;
            r_ltu   <= 1'b0;
            r_lt    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in0;
            r_b     <= in1;
            r_carry <= ~bin;
            r_cnt   <= '0;
        end else if (w_calc) begin
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_diff  <= w_diff_full;
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + c_cnt_one;
            if (w_last) begin
                r_bout <= ~w_carry_out;
                r_ltu  <= ~w_carry_out;
                r_eq   <= (w_diff_full == '0);
                r_lt   <= w_diff_full[WIDTH-1] ^ w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_subtractor_iterative_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_iterative_32b
// Description : Self-checking bench for subtractor_iterative_32b. Directed
//               vector table, randomized operations against an arithmetic
//               reference model, plus backpressure and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_iterative_32b;

    logic        clk;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        bin;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] diff;
    logic        bout;
    logic        eq;
    logic        ltu;
    logic        lt;

    int n_vec;
    int n_err;

    subtractor_iterative_32b dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .bin         (bin),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .diff        (diff),
        .bout        (bout),
        .eq          (eq),
        .ltu         (ltu),
        .lt          (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        e;
        logic        lu;
        logic        ls;
    } vec_t;

    vec_t tbl[9];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic in 34 bits, then read off the
    // modular difference, unsigned borrow and true signed sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                  output logic [31:0] d, output logic bo, output logic e,
                                  output logic lu, output logic ls);
        logic [33:0] u;
        logic [33:0] s;
        u  = {2'b00, a} - {2'b00, b} - {33'd0, bi};
        s  = {{2{a[31]}}, a} - {{2{b[31]}}, b} - {33'd0, bi};
        d  = u[31:0];
        bo = u[33];
        e  = (u[31:0] == 32'd0);
        lu = u[33];
        ls = s[33];
    endfunction

    // Wait (bounded) for the result to appear; lat counts edges waited.
    task automatic wait_val(output int lat);
        lat = 0;
        while (ostream_val !== 1'b1 && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One complete request/response from IDLE; inputs are scrambled right
    // after acceptance to show they were latched.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, output logic [31:0] d, output logic bo,
                          output logic e, output logic lu, output logic ls);
        int lat;
        @(negedge clk);
        chk1({nm, " rdy_before"}, istream_rdy, 1'b1);
        in0 = a;
        in1 = b;
        bin = bi;
        istream_val = 1'b1;
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        in0 = ~a;
        in1 = $urandom;
        bin = ~bi;
        wait_val(lat);
        chkint({nm, " latency"}, lat, 4);
        d  = diff;
        bo = bout;
        e  = eq;
        lu = ltu;
        ls = lt;
        @(negedge clk);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic bi, input logic [31:0] xd, input logic xbo,
                            input logic xe, input logic xlu, input logic xls);
        logic [31:0] d;
        logic bo, e, lu, ls;
        run_op(nm, a, b, bi, d, bo, e, lu, ls);
        chk32({nm, " diff"}, d, xd);
        chk1({nm, " bout"}, bo, xbo);
        chk1({nm, " eq"}, e, xe);
        chk1({nm, " ltu"}, lu, xlu);
        chk1({nm, " lt"}, ls, xls);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] snap_d;
        logic [3:0]  snap_f;
        logic        stable;
        logic        busy_ok;
        logic        seen;
        int          lat;
        logic [31:0] ra, rb, xd;
        logic        rbi, xbo, xe, xlu, xls;
        logic [31:0] specials[6];

        n_vec = 0;
        n_err = 0;

        //          a             b             bi    diff          bo    eq    ltu   lt
        tbl[0] = '{32'd5,        32'd3,        1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        specials[0] = 32'h00000000;
        specials[1] = 32'hFFFFFFFF;
        specials[2] = 32'h80000000;
        specials[3] = 32'h7FFFFFFF;
        specials[4] = 32'h00000001;
        specials[5] = 32'h00FF00FF;

        reset       = 1'b0;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        in0         = 32'd0;
        in1         = 32'd0;
        bin         = 1'b0;

        // Reset state.
        #12;
        chk1("reset istream_rdy", istream_rdy, 1'b1);
        chk1("reset ostream_val", ostream_val, 1'b0);
        chk32("reset diff", diff, 32'd0);
        chk32("reset flags", {28'd0, bout, eq, ltu, lt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bi,
                     tbl[i].d, tbl[i].bo, tbl[i].e, tbl[i].lu, tbl[i].ls);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = specials[$urandom_range(0, 5)]; rb = specials[$urandom_range(0, 5)]; end
                default: begin ra = $urandom; rb = ra + 32'($urandom_range(0, 2)) - 32'd1; end
            endcase
            rbi = 1'($urandom_range(0, 1));
            model(ra, rb, rbi, xd, xbo, xe, xlu, xls);
            check_op($sformatf("rnd%0d", i), ra, rb, rbi, xd, xbo, xe, xlu, xls);
        end

        // Backpressure: hold the result 5 cycles with istream_val kept high.
        @(negedge clk);
        in0 = 32'd7;
        in1 = 32'd2;
        bin = 1'b0;
        istream_val = 1'b1;
        @(posedge clk);
        #1;
        in0 = 32'd20;
        in1 = 32'd5;
        wait_val(lat);
        chkint("bp latency", lat, 4);
        chk32("bp diff", diff, 32'd5);
        snap_d  = diff;
        snap_f  = {bout, eq, ltu, lt};
        stable  = 1'b1;
        busy_ok = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (diff !== snap_d || {bout, eq, ltu, lt} !== snap_f || ostream_val !== 1'b1)
                stable = 1'b0;
            if (istream_rdy !== 1'b0)
                busy_ok = 1'b0;
        end
        chk1("bp outputs stable", stable, 1'b1);
        chk1("bp istream_rdy low", busy_ok, 1'b1);
        @(negedge clk);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        chk1("bp back to idle rdy", istream_rdy, 1'b1);
        chk1("bp back to idle val", ostream_val, 1'b0);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        chk1("bp next accepted", istream_rdy, 1'b0);
        wait_val(lat);
        chkint("bp2 latency", lat, 4);
        chk32("bp2 diff", diff, 32'd15);
        @(negedge clk);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;

        // Asynchronous reset during the second CALC cycle.
        @(negedge clk);
        in0 = 32'd100;
        in1 = 32'd1;
        bin = 1'b0;
        istream_val = 1'b1;
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        chk1("rst op accepted", istream_rdy, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk1("rst istream_rdy", istream_rdy, 1'b1);
        chk1("rst ostream_val", ostream_val, 1'b0);
        chk32("rst diff cleared", diff, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ostream_val === 1'b1)
                seen = 1'b1;
        end
        chk1("rst no result", seen, 1'b0);
        check_op("post_rst", 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subtractor_iterative_32b.md
Name: subtractor_iterative_32b

Overview:
- Multi-cycle 32-bit subtract/compare unit: diff = in0 - in1 - bin, plus borrow and compare flags.
- Processes one 8-bit digit per cycle, least-significant digit first, with a single 8-bit adder datapath: a + ~b + carry, where carry = ~borrow.
- Uses latency-insensitive val/rdy streams.
- Serves as the borrow/subtract counterpart to the 8-bit carry-select adder.
- Sits in the TinyRV1 execute-stage area for SUB and branch compares.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of DIGIT_W.
- DIGIT_W, 8: bits processed per CALC cycle.
- NDIGITS, WIDTH/DIGIT_W (= 4): number of CALC cycles. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately, independent of clk.
- istream_val  input  1  request valid.
- istream_rdy  output  1  unit can accept a request.
- in0  input  WIDTH  minuend.
- in1  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  consumer can accept the result.
- diff  output  WIDTH  in0 - in1 - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 iff in0 < in1 + bin (unsigned, infinite precision).
- eq  output  1  diff == 0.
- ltu  output  1  equals bout.
- lt  output  1  signed less-than: N xor V, where N = diff[WIDTH-1] and V = (in0[MSB] != in1[MSB]) && (diff[MSB] != in0[MSB]).

Behaviour:
- States: IDLE, CALC, DONE. Internal digit counter cnt is log2(NDIGITS) bits.
- Reset (reset=0):
  - state = IDLE, cnt = 0, internal carry = 0.
  - diff/bout/eq/ltu/lt registers = 0.
  - istream_rdy = 1 and ostream_val = 0 combinationally from the state.
  - Reset mid-CALC or mid-DONE abandons the operation; no result is ever presented.
- IDLE:
  - istream_rdy = 1, ostream_val = 0.
  - On an edge with istream_val=1, latch in0, in1 and bin.
  - Initialise carry = ~bin, cnt = 0, next state = CALC.
- CALC (istream_rdy = 0, ostream_val = 0). Each edge:
  - {c, d} = in0 digit[cnt] + ~in1 digit[cnt] + carry, all DIGIT_W-bit digits.
  - Write d into diff digit[cnt]; carry <= c; cnt <= cnt + 1.
  - On the edge where cnt == NDIGITS-1, go to DONE. On that same edge, register bout = ~c_final and compute eq, ltu, lt from the completed diff.
- DONE:
  - ostream_val = 1, istream_rdy = 0.
  - Outputs stay stable while ostream_rdy = 0, for an unbounded number of cycles.
  - On an edge with ostream_rdy = 1, go to IDLE.
- Latency: request accepted at edge N; ostream_val first high after edge N+NDIGITS (4 cycles).
- Throughput: at most one operation per NDIGITS+2 cycles. There is no accept-in-DONE overlap.
- istream_val while busy is ignored and not queued. in0, in1 and bin may change freely after acceptance.
- diff/flags outputs hold their last values in IDLE. They are meaningful only while ostream_val = 1.
- Wrap-around: result is modulo 2^WIDTH; bout reports underflow.
- Example: 0 - 0 - 1 gives diff = all ones, bout = 1.
- eq is set only on a zero difference. A compare use must drive bin = 0.

Test Plan:
- Basic, backpressure and reset scenarios start from IDLE after reset release.
- Basic:
  - Stimulus: in0 = 5, in1 = 3, bin = 0.
  - Required: ostream_val rises 4 cycles after accept; diff = 0x00000002, bout = 0, eq = 0, ltu = 0, lt = 0.
- Underflow:
  - Stimulus: in0 = 0x00000000, in1 = 0x00000001, bin = 0.
  - Required: diff = 0xFFFFFFFF, bout = 1, ltu = 1, lt = 1, eq = 0.
  - Stimulus: in0 = 0, in1 = 0, bin = 1.
  - Required: diff = 0xFFFFFFFF, bout = 1.
- Signed overflow:
  - Stimulus: in0 = 0x80000000, in1 = 0x00000001.
  - Required: diff = 0x7FFFFFFF, bout = 0, ltu = 0, lt = 1.
  - Stimulus: in0 = 0x7FFFFFFF, in1 = 0xFFFFFFFF.
  - Required: diff = 0x80000000, bout = 1, lt = 0.
- Equality and cross-digit borrow:
  - Stimulus: in0 = in1 = 0x12345678.
  - Required: diff = 0, eq = 1, bout = 0.
  - Stimulus: in0 = 0x00000100, in1 = 0x00000001.
  - Required: diff = 0x000000FF, exercising the borrow between digits.
- Backpressure:
  - Stimulus: hold ostream_rdy = 0 for 5 cycles in DONE, then set it to 1; keep istream_val = 1 throughout.
  - Required: outputs stable and istream_rdy = 0 during the hold; return to IDLE; next request accepted only from IDLE.
- Reset mid-operation:
  - Stimulus: assert reset = 0 asynchronously between clock edges during the 2nd CALC cycle.
  - Required: istream_rdy = 1 and ostream_val = 0 immediately; no result appears after release.
  - Then: a new request 9 - 9 completes normally with eq = 1.
